// File: rtl/cpu_ad48_trap_ctrl_if.sv
// Commit-point, CSR-write and fetch-redirect signals shared between the
// cpu_ad48 pipeline and its trap sequencer.
interface cpu_ad48_trap_ctrl_if;
    // Commit point
    logic        commit_valid;
    logic [47:0] commit_pc;
    logic        exc_valid;
    logic [3:0]  exc_cause;
    logic        eret_valid;

    // CSR write port
    logic        csr_we;
    logic [1:0]  csr_addr;
    logic [47:0] csr_wdata;

    // Pipeline control and fetch redirect handshake
    logic        flush;
    logic        redirect_valid;
    logic [47:0] redirect_pc;
    logic        redirect_ack;
    logic        busy;

    // Core side: drives commit/CSR traffic, consumes flush and redirect
    modport master (
        output commit_valid, commit_pc, exc_valid, exc_cause, eret_valid,
        output csr_we, csr_addr, csr_wdata,
        output redirect_ack,
        input  flush, redirect_valid, redirect_pc, busy
    );

    // Trap sequencer side
    modport slave (
        input  commit_valid, commit_pc, exc_valid, exc_cause, eret_valid,
        input  csr_we, csr_addr, csr_wdata,
        input  redirect_ack,
        output flush, redirect_valid, redirect_pc, busy
    );
endinterface

// File: rtl/cpu_ad48_trap_ctrl.sv
// Trap/interrupt sequencer for the cpu_ad48 core. Arbitrates commit-point
// exceptions, trap returns and masked external interrupts; owns STATUS, EPC,
// CAUSE, IRQ_EN and INSTRET; flushes the pipeline and redirects fetch.
module cpu_ad48_trap_ctrl #(
    parameter int unsigned IRQ_LINES   = 4,
    parameter logic [47:0] TRAP_VECTOR = 48'd32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [IRQ_LINES-1:0] irq,
    cpu_ad48_trap_ctrl_if.slave  bus,
    output logic [47:0]          csr_status,
    output logic [47:0]          csr_epc,
    output logic [47:0]          csr_cause,
    output logic [47:0]          csr_instret,
    output logic [1:0]           priv_mode
);

    typedef enum logic [1:0] {
        StIdle,
        StFlush,
        StRedir
    } state_e;

    // STATUS field positions
    localparam int unsigned PrvLo  = 0;
    localparam int unsigned PprvLo = 2;
    localparam int unsigned IeBit  = 4;
    localparam int unsigned PieBit = 5;

    localparam logic [5:0] StatusReset = 6'b00_0011;

    state_e               state_q, state_d;
    logic [5:0]           status_q, status_d;
    logic [47:0]          epc_q, epc_d;
    logic [47:0]          cause_q, cause_d;
    logic [47:0]          instret_q, instret_d;
    logic [IRQ_LINES-1:0] irq_en_q, irq_en_d;
    logic [IRQ_LINES-1:0] irq_q;
    logic [47:0]          target_q, target_d;
    logic                 redir_valid_q, redir_valid_d;
    logic [47:0]          redir_pc_q, redir_pc_d;

    logic [IRQ_LINES-1:0] pending;
    logic                 int_req;
    logic [3:0]           irq_idx;
    logic                 take_exc;
    logic                 take_eret;
    logic                 take_int;

    // Interrupt qualification and lowest-index pending line select
    always_comb begin
        pending = irq_q & irq_en_q;
        int_req = status_q[IeBit] & (|pending);
        irq_idx = 4'd0;
        for (int i = int'(IRQ_LINES) - 1; i >= 0; i--) begin
            if (pending[i]) begin
                irq_idx = 4'(i);
            end
        end
    end

    // Sequencer next state, CSR updates and redirect register inputs
    always_comb begin
        state_d       = state_q;
        status_d      = status_q;
        epc_d         = epc_q;
        cause_d       = cause_q;
        instret_d     = instret_q;
        irq_en_d      = irq_en_q;
        target_d      = target_q;
        redir_valid_d = redir_valid_q;
        redir_pc_d    = redir_pc_q;
        take_exc      = 1'b0;
        take_eret     = 1'b0;
        take_int      = 1'b0;

        unique case (state_q)
            StIdle: begin
                take_exc  = bus.commit_valid & bus.exc_valid;
                take_eret = bus.commit_valid & ~bus.exc_valid & bus.eret_valid;
                take_int  = bus.commit_valid & ~bus.exc_valid & ~bus.eret_valid & int_req;

                if (take_exc || take_int) begin
                    // Faulting or interrupted instruction does not retire
                    epc_d   = bus.commit_pc;
                    cause_d = take_exc ? {44'd0, bus.exc_cause} : {1'b1, 43'd0, irq_idx};
                    status_d[PieBit]           = status_q[IeBit];
                    status_d[IeBit]            = 1'b0;
                    status_d[PprvLo+1:PprvLo]  = status_q[PrvLo+1:PrvLo];
                    status_d[PrvLo+1:PrvLo]    = 2'd3;
                    target_d = TRAP_VECTOR;
                    state_d  = StFlush;
                end else if (take_eret) begin
                    status_d[PrvLo+1:PrvLo]   = status_q[PprvLo+1:PprvLo];
                    status_d[IeBit]           = status_q[PieBit];
                    status_d[PprvLo+1:PprvLo] = 2'd0;
                    status_d[PieBit]          = 1'b1;
                    target_d  = epc_q;
                    instret_d = instret_q + 48'd1;
                    state_d   = StFlush;
                end else begin
                    if (bus.commit_valid) begin
                        instret_d = instret_q + 48'd1;
                    end
                    // CSR writes only land when no trap/eret claims this cycle
                    if (bus.csr_we) begin
                        case (bus.csr_addr)
                            2'd0:    status_d = bus.csr_wdata[5:0];
                            2'd1:    epc_d    = bus.csr_wdata;
                            2'd2:    cause_d  = bus.csr_wdata;
                            default: irq_en_d = bus.csr_wdata[IRQ_LINES-1:0];
                        endcase
                    end
                end
            end

            StFlush: begin
                redir_valid_d = 1'b1;
                redir_pc_d    = target_q;
                state_d       = StRedir;
            end

            StRedir: begin
                if (bus.redirect_ack) begin
                    redir_valid_d = 1'b0;
                    state_d       = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and architectural register update
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= StIdle;
            status_q      <= StatusReset;
            epc_q         <= 48'd0;
            cause_q       <= 48'd0;
            instret_q     <= 48'd0;
            irq_en_q      <= '0;
            irq_q         <= '0;
            target_q      <= 48'd0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= 48'd0;
        end else begin
            state_q       <= state_d;
            status_q      <= status_d;
            epc_q         <= epc_d;
            cause_q       <= cause_d;
            instret_q     <= instret_d;
            irq_en_q      <= irq_en_d;
            irq_q         <= irq;
            target_q      <= target_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
        end
    end

    // Output mapping
    always_comb begin
        bus.flush          = (state_q == StFlush);
        bus.busy           = (state_q != StIdle);
        bus.redirect_valid = redir_valid_q;
        bus.redirect_pc    = redir_pc_q;
        csr_status         = {42'd0, status_q};
        csr_epc            = epc_q;
        csr_cause          = cause_q;
        csr_instret        = instret_q;
        priv_mode          = status_q[PrvLo+1:PrvLo];
    end

endmodule

// File: tb/tb_cpu_ad48_trap_ctrl.sv
// Directed cycle-by-cycle vectors for cpu_ad48_trap_ctrl plus an
// asynchronous reset taken while a redirect is outstanding.
module tb_cpu_ad48_trap_ctrl;

    typedef struct {
        logic        cv;
        logic [47:0] pc;
        logic        ev;
        logic [3:0]  ec;
        logic        er;
        logic        we;
        logic [1:0]  ad;
        logic [47:0] wd;
        logic [3:0]  irq;
        logic        ack;
        logic        fl;
        logic        rv;
        logic [47:0] rpc;
        logic        bsy;
        logic [47:0] epc;
        logic [47:0] cau;
        logic [5:0]  st;
        logic [47:0] ins;
    } vec_t;

    localparam longint C1 = 64'h8000_0000_0001;
    localparam longint C3 = 64'h8000_0000_0003;

    logic        clk;
    logic        resetn;
    logic [3:0]  irq;
    logic [47:0] csr_status;
    logic [47:0] csr_epc;
    logic [47:0] csr_cause;
    logic [47:0] csr_instret;
    logic [1:0]  priv_mode;

    int checks;
    int errors;

    cpu_ad48_trap_ctrl_if bus ();

    cpu_ad48_trap_ctrl #(
        .IRQ_LINES   (4),
        .TRAP_VECTOR (48'd32)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .irq         (irq),
        .bus         (bus),
        .csr_status  (csr_status),
        .csr_epc     (csr_epc),
        .csr_cause   (csr_cause),
        .csr_instret (csr_instret),
        .priv_mode   (priv_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t v(int cv, longint pc, int ev, int ec, int er,
                               int we, int ad, longint wd, int irqv, int ack,
                               int fl, int rv, longint rpc, int bsy,
                               longint epc, longint cau, int st, longint ins);
        vec_t r;
        r.cv  = cv[0];
        r.pc  = 48'(pc);
        r.ev  = ev[0];
        r.ec  = 4'(ec);
        r.er  = er[0];
        r.we  = we[0];
        r.ad  = 2'(ad);
        r.wd  = 48'(wd);
        r.irq = 4'(irqv);
        r.ack = ack[0];
        r.fl  = fl[0];
        r.rv  = rv[0];
        r.rpc = 48'(rpc);
        r.bsy = bsy[0];
        r.epc = 48'(epc);
        r.cau = 48'(cau);
        r.st  = 6'(st);
        r.ins = 48'(ins);
        return r;
    endfunction

    task automatic chk(input string nm, input int row, input logic [47:0] act,
                       input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL row %0d %s: got %h expected %h", row, nm, act, exp);
        end
    endtask

    task automatic check_all(input vec_t r, input int row);
        chk("flush", row, {47'd0, bus.flush}, {47'd0, r.fl});
        chk("redirect_valid", row, {47'd0, bus.redirect_valid}, {47'd0, r.rv});
        chk("redirect_pc", row, bus.redirect_pc, r.rpc);
        chk("busy", row, {47'd0, bus.busy}, {47'd0, r.bsy});
        chk("epc", row, csr_epc, r.epc);
        chk("cause", row, csr_cause, r.cau);
        chk("status", row, csr_status, {42'd0, r.st});
        chk("instret", row, csr_instret, r.ins);
        chk("priv_mode", row, {46'd0, priv_mode}, {46'd0, r.st[1:0]});
    endtask

    task automatic drive(input vec_t r);
        bus.commit_valid = r.cv;
        bus.commit_pc    = r.pc;
        bus.exc_valid    = r.ev;
        bus.exc_cause    = r.ec;
        bus.eret_valid   = r.er;
        bus.csr_we       = r.we;
        bus.csr_addr     = r.ad;
        bus.csr_wdata    = r.wd;
        bus.redirect_ack = r.ack;
        irq              = r.irq;
    endtask

    task automatic apply(input vec_t r, input int row);
        @(negedge clk);
        drive(r);
        @(posedge clk);
        #1;
        check_all(r, row);
    endtask

    vec_t vecs[$];
    vec_t post[$];
    vec_t rst_exp;

    initial begin
        checks = 0;
        errors = 0;
        resetn = 1'b0;
        rst_exp = v(0,0,0,0,0, 0,0,0, 0,0, 0,0,0,0, 0,0,'h03,0);
        drive(rst_exp);

        // cv pc ev ec er | we ad wd | irq ack || fl rv rpc bsy | epc cause status instret
        // Illegal instruction at pc 0
        vecs.push_back(v(1,0,1,2,0,      0,0,0,     0,0,   1,0,0,1,     0,2,'h0F,0));
        vecs.push_back(v(0,0,0,0,0,      0,0,0,     0,0,   0,1,32,1,    0,2,'h0F,0));
        vecs.push_back(v(0,0,0,0,0,      0,0,0,     0,1,   0,0,32,0,    0,2,'h0F,0));
        // Two clean retires then misaligned store at pc 2
        vecs.push_back(v(1,0,0,0,0,      0,0,0,     0,0,   0,0,32,0,    0,2,'h0F,1));
        vecs.push_back(v(1,1,0,0,0,      0,0,0,     0,0,   0,0,32,0,    0,2,'h0F,2));
        vecs.push_back(v(1,2,1,6,0,      0,0,0,     0,0,   1,0,32,1,    2,6,'h0F,2));
        vecs.push_back(v(0,0,0,0,0,      0,0,0,     0,0,   0,1,32,1,    2,6,'h0F,2));
        vecs.push_back(v(0,0,0,0,0,      0,0,0,     0,1,   0,0,32,0,    2,6,'h0F,2));
        // IRQ_EN=F, STATUS IE=1 PRV=0, irq 1010 held, interrupt at pc 5
        vecs.push_back(v(0,0,0,0,0,      1,3,'hF,   0,0,   0,0,32,0,    2,6,'h0F,2));
        vecs.push_back(v(0,0,0,0,0,      1,0,'h10,  'hA,0, 0,0,32,0,    2,6,'h10,2));
        vecs.push_back(v(1,5,0,0,0,      0,0,0,     'hA,0, 1,0,32,1,    5,C1,'h23,2));
        vecs.push_back(v(0,0,0,0,0,      0,0,0,     'hA,0, 0,1,32,1,    5,C1,'h23,2));
        vecs.push_back(v(0,0,0,0,0,      0,0,0,     'hA,1, 0,0,32,0,    5,C1,'h23,2));
        // IE=0 now: irq still pending but commit retires
        vecs.push_back(v(1,6,0,0,0,      0,0,0,     'hA,0, 0,0,32,0,    5,C1,'h23,3));
        // Exception beats pending interrupt, then eret, then interrupt taken
        vecs.push_back(v(0,0,0,0,0,      1,0,'h10,  'hA,0, 0,0,32,0,    5,C1,'h10,3));
        vecs.push_back(v(1,8,1,3,0,      0,0,0,     'hA,0, 1,0,32,1,    8,3,'h23,3));
        vecs.push_back(v(0,0,0,0,0,      0,0,0,     'hA,0, 0,1,32,1,    8,3,'h23,3));
        vecs.push_back(v(0,0,0,0,0,      0,0,0,     'hA,1, 0,0,32,0,    8,3,'h23,3));
        vecs.push_back(v(1,'h20,0,0,1,   0,0,0,     'hA,0, 1,0,32,1,    8,3,'h30,4));
        vecs.push_back(v(0,0,0,0,0,      0,0,0,     'hA,0, 0,1,8,1,     8,3,'h30,4));
        vecs.push_back(v(0,0,0,0,0,      0,0,0,     'hA,1, 0,0,8,0,     8,3,'h30,4));
        vecs.push_back(v(1,8,0,0,0,      0,0,0,     'hA,0, 1,0,8,1,     8,C1,'h23,4));
        vecs.push_back(v(0,0,0,0,0,      0,0,0,     'hA,0, 0,1,32,1,    8,C1,'h23,4));
        vecs.push_back(v(0,0,0,0,0,      0,0,0,     0,1,   0,0,32,0,    8,C1,'h23,4));
        // eret to EPC=0x40, redirect held 3 cycles; commits and CSR writes ignored while busy
        vecs.push_back(v(0,0,0,0,0,      1,1,'h40,  0,0,   0,0,32,0,    'h40,C1,'h23,4));
        vecs.push_back(v(1,'h30,0,0,1,   0,0,0,     0,0,   1,0,32,1,    'h40,C1,'h30,5));
        vecs.push_back(v(0,0,0,0,0,      0,0,0,     0,0,   0,1,'h40,1,  'h40,C1,'h30,5));
        vecs.push_back(v(1,'h50,1,2,0,   0,0,0,     0,0,   0,1,'h40,1,  'h40,C1,'h30,5));
        vecs.push_back(v(0,0,0,0,0,      1,2,'h77,  0,0,   0,1,'h40,1,  'h40,C1,'h30,5));
        vecs.push_back(v(0,0,0,0,0,      0,0,0,     0,1,   0,0,'h40,0,  'h40,C1,'h30,5));
        // Trap at pc 7 beats EPC write of 0x99
        vecs.push_back(v(1,7,1,2,0,      1,1,'h99,  0,0,   1,0,'h40,1,  7,2,'h23,5));
        vecs.push_back(v(0,0,0,0,0,      0,0,0,     0,0,   0,1,32,1,    7,2,'h23,5));

        // After mid-REDIR reset: masking, deassert-before-arbitration, lowest index, early ack
        post.push_back(v(0,0,0,0,0,      1,3,'h4,   0,0,   0,0,0,0,     0,0,'h03,0));
        post.push_back(v(0,0,0,0,0,      1,0,'h10,  8,0,   0,0,0,0,     0,0,'h10,0));
        post.push_back(v(1,1,0,0,0,      0,0,0,     8,0,   0,0,0,0,     0,0,'h10,1));
        post.push_back(v(0,0,0,0,0,      1,3,'hF,   8,0,   0,0,0,0,     0,0,'h10,1));
        post.push_back(v(0,0,0,0,0,      0,0,0,     0,0,   0,0,0,0,     0,0,'h10,1));
        post.push_back(v(1,2,0,0,0,      0,0,0,     0,0,   0,0,0,0,     0,0,'h10,2));
        post.push_back(v(0,0,0,0,0,      0,0,0,     'hC,0, 0,0,0,0,     0,0,'h10,2));
        post.push_back(v(1,3,0,0,0,      0,0,0,     'hC,0, 1,0,0,1,     3,'h8000_0000_0002,'h23,2));
        post.push_back(v(0,0,0,0,0,      0,0,0,     0,1,   0,1,32,1,    3,'h8000_0000_0002,'h23,2));
        post.push_back(v(0,0,0,0,0,      0,0,0,     0,1,   0,0,32,0,    3,'h8000_0000_0002,'h23,2));
        post.push_back(v(0,0,0,0,0,      0,0,0,     8,0,   0,0,32,0,    3,'h8000_0000_0002,'h23,2));
        post.push_back(v(1,4,0,0,0,      0,0,0,     8,0,   0,0,32,0,    3,'h8000_0000_0002,'h23,3));
        // Re-enable IE and take line 3 alone
        post.push_back(v(0,0,0,0,0,      1,0,'h10,  8,0,   0,0,32,0,    3,'h8000_0000_0002,'h10,3));
        post.push_back(v(1,9,0,0,0,      0,0,0,     8,0,   1,0,32,1,    9,C3,'h23,3));

        repeat (3) @(posedge clk);
        #1;
        check_all(rst_exp, -1);
        @(negedge clk);
        resetn = 1'b1;

        foreach (vecs[i]) apply(vecs[i], i);

        // Asynchronous reset mid-cycle while in REDIR
        #2;
        resetn = 1'b0;
        #1;
        check_all(rst_exp, 100);
        @(negedge clk);
        resetn = 1'b1;

        foreach (post[i]) apply(post[i], 200 + i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
